// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and load/store.
// Optional macro UNIFIED_MEM_RR_EN switches tie-breaking from strict data priority to round-robin.
module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                d_stall,
   output logic                err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [15:0]         conflict_cnt
);

   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

   state_t            state;
   logic              owner_d;
   logic [TCNT_W-1:0] tcnt;
   logic              d_wins;
   logic              conflict_hit;

   assign if_stall = if_req && !if_valid;
   assign d_stall  = d_req && !d_valid;

   // owner_d doubles as the last-served flag; it resets to fetch so data wins the first tie
`ifdef UNIFIED_MEM_RR_EN
   assign d_wins = d_req && (!if_req || !owner_d);
`else
   assign d_wins = d_req;
`endif

   assign conflict_hit = if_req && ((state == BUSY_D) ||
                                    (state == RESP && owner_d) ||
                                    (state == IDLE && d_wins));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner_d      <= 1'b0;
         tcnt         <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         err          <= 1'b0;
         if_rdata     <= '0;
         d_rdata      <= '0;
         conflict_cnt <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         err      <= 1'b0;
         if (conflict_hit && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;

         case (state)
            IDLE: begin
               tcnt <= '0;
               if (d_wins) begin
                  state     <= BUSY_D;
                  owner_d   <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_be    <= d_be;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (if_req) begin
                  state     <= BUSY_I;
                  owner_d   <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= '0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end
            end
            BUSY_D, BUSY_I: begin
               // A timed-out transaction completes like a normal one but returns zero with err
               if (mem_ack || tcnt == TLAST) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
                  err     <= !mem_ack;
                  if (state == BUSY_D) begin
                     d_valid <= 1'b1;
                     d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                  end else begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_ack ? mem_rdata : '0;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter with a transaction-level memory/latency model.
// Honors UNIFIED_MEM_RR_EN when choosing expected grant order.
module tb_unified_mem_arbiter;

   localparam int TO = 64;
`ifdef UNIFIED_MEM_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] if_rdata, d_rdata;
   logic        if_valid, if_stall, d_valid, d_stall, err;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] conflict_cnt;

   int          total = 0;
   int          bad = 0;
   logic [31:0] tbmem [256];
   logic [31:0] ref_mem [256];
   int          wait_cfg = 0;
   bit          noack = 1'b0;
   bit          spur = 1'b0;
   int          busy_cnt = 0;
   int          mreq_cycles = 0;
   int          conf_exp = 0;
   bit          last_d = 1'b0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .conflict_cnt(conflict_cnt)
   );

   // Memory responder: acks after wait_cfg stall cycles, returns garbage when not acking
   always @(negedge clk) begin
      if (mem_req) begin
         mreq_cycles++;
         if (!noack && busy_cnt == wait_cfg) begin
            mem_ack   = 1'b1;
            mem_rdata = tbmem[mem_addr[9:2]];
            if (mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) tbmem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            busy_cnt  = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            busy_cnt++;
         end
      end else begin
         mem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rdata = $urandom;
         busy_cnt  = 0;
      end
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request from a single client; latency, data, stall and command fields are checked
   task automatic apply_single(input bit is_d, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int waits, input bit to, input string tag);
      int          exp_lat;
      logic [31:0] exp_data;
      logic [7:0]  idx;
      int          n;
      bit          got;
      logic        vld;
      idx      = addr[9:2];
      exp_lat  = to ? TO + 1 : 2 + waits;
      exp_data = (to || (is_d && we)) ? 32'h0 : ref_mem[idx];
      wait_cfg = waits;
      noack    = to;
      @(posedge clk); #1;
      mreq_cycles = 0;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < exp_lat + 10) begin
         @(negedge clk);
         vld = is_d ? d_valid : if_valid;
         if (vld) begin
            got = 1'b1;
         end else begin
            check_output({tag, "_stall"}, is_d ? d_stall : if_stall, 1'b1);
            if (mem_req) begin
               check_output({tag, "_mem_addr"}, mem_addr, addr);
               check_output({tag, "_mem_we"}, mem_we, is_d && we);
               if (is_d && we) begin
                  check_output({tag, "_mem_be"}, mem_be, be);
                  check_output({tag, "_mem_wdata"}, mem_wdata, wdata);
               end
            end
            n++;
         end
      end
      check_output({tag, "_latency"}, n, exp_lat);
      if (got) begin
         check_output({tag, "_rdata"}, is_d ? d_rdata : if_rdata, exp_data);
         check_output({tag, "_err"}, err, to);
         check_output({tag, "_other_valid"}, is_d ? if_valid : d_valid, 1'b0);
         check_output({tag, "_stall_at_valid"}, is_d ? d_stall : if_stall, 1'b0);
      end
      if (to) check_output({tag, "_mem_req_cycles"}, mreq_cycles, TO);
      if (is_d && we && !to)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      last_d = is_d;
      check_output({tag, "_conflict"}, conflict_cnt, conf_exp);
   endtask

   // Fetch and load arrive together; the winner completes at 2+w, the loser at 5+2w
   task automatic apply_pair(input logic [31:0] iaddr, input logic [31:0] daddr,
                             input int waits, input string tag);
      bit   first_d;
      int   d_at, i_at;
      logic dv, iv;
      first_d  = RR ? !last_d : 1'b1;
      d_at     = -1;
      i_at     = -1;
      wait_cfg = waits;
      noack    = 1'b0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = iaddr;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'($urandom); d_addr = daddr; d_wdata = $urandom;
      for (int n = 0; n < 2 * waits + 20 && (d_at < 0 || i_at < 0); n++) begin
         @(negedge clk);
         dv = d_valid;
         iv = if_valid;
         if (dv) begin
            d_at = n;
            check_output({tag, "_d_rdata"}, d_rdata, ref_mem[daddr[9:2]]);
            if (first_d) check_output({tag, "_conflict_at_dvalid"}, conflict_cnt, conf_exp + 2 + waits);
         end
         if (iv) begin
            i_at = n;
            check_output({tag, "_if_rdata"}, if_rdata, ref_mem[iaddr[9:2]]);
         end
         @(posedge clk); #1;
         if (dv) d_req = 1'b0;
         if (iv) if_req = 1'b0;
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      check_output({tag, "_d_cycle"}, d_at, first_d ? 2 + waits : 5 + 2 * waits);
      check_output({tag, "_if_cycle"}, i_at, first_d ? 5 + 2 * waits : 2 + waits);
      if (first_d) conf_exp += 3 + waits;
      check_output({tag, "_conflict"}, conflict_cnt, conf_exp);
      last_d = !first_d;
   endtask

   // Both clients keep requesting; four grants are observed and their owners checked
   task automatic apply_stream(input logic [31:0] iaddr, input logic [31:0] daddr);
      int   g;
      bit   exp_d;
      logic dv, iv;
      g        = 0;
      wait_cfg = 0;
      noack    = 1'b0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = iaddr;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = daddr; d_wdata = 32'h0;
      for (int n = 0; n < 60 && g < 4; n++) begin
         @(negedge clk);
         dv = d_valid;
         iv = if_valid;
         if (dv || iv) begin
            exp_d = RR ? !last_d : 1'b1;
            check_output("stream_owner", dv, exp_d);
            check_output("stream_rdata", dv ? d_rdata : if_rdata,
                         dv ? ref_mem[daddr[9:2]] : ref_mem[iaddr[9:2]]);
            if (exp_d) conf_exp += 3;
            last_d = dv;
            g++;
            if (g == 4) begin
               @(posedge clk); #1;
               if_req = 1'b0;
               d_req  = 1'b0;
            end
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      check_output("stream_grants", g, 4);
      check_output("stream_conflict", conflict_cnt, conf_exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         tbmem[i]   = $urandom;
         ref_mem[i] = tbmem[i];
      end
      tbmem[8'h40]   = 32'hE3A00001;
      ref_mem[8'h40] = 32'hE3A00001;
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      $display("[TB] start, RR=%0d", RR);

      repeat (2) @(negedge clk);
      check_output("rst_mem_req", mem_req, 1'b0);
      check_output("rst_mem_addr", mem_addr, 32'h0);
      check_output("rst_valids", {if_valid, d_valid, err}, 3'b000);
      check_output("rst_rdata", {if_rdata, d_rdata}, 64'h0);
      check_output("rst_conflict", conflict_cnt, 16'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      apply_single(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 0, 1'b0, "fetch_0x100");
      apply_pair(32'h200, 32'h400, 2, "pair_dprio");
      apply_single(1'b1, 1'b1, 4'b0011, 32'h104, 32'hDEADBEEF, 1, 1'b0, "store_be0011");
      apply_single(1'b1, 1'b0, 4'hF, 32'h104, 32'h0, 0, 1'b0, "load_after_store");
      apply_single(1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 0, 1'b1, "timeout");
      apply_single(1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1, 1'b0, "after_timeout");

      // Reset while a fetch waits on a silent memory
      wait_cfg = 0;
      noack    = 1'b1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h300;
      repeat (3) @(negedge clk);
      check_output("busy_before_reset", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_rst_mem_req", mem_req, 1'b0);
      check_output("async_rst_outputs", {if_valid, d_valid, err, mem_we}, 4'b0000);
      check_output("async_rst_fields", {mem_addr, if_rdata}, 64'h0);
      check_output("async_rst_conflict", conflict_cnt, 16'h0);
      if_req = 1'b0;
      noack  = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      conf_exp = 0;
      last_d   = 1'b0;

      apply_stream(32'h10, 32'h20);

      spur = 1'b1;
      for (int k = 0; k < 40; k++) begin
         int          kind;
         int          w;
         logic [31:0] a1, a2;
         kind = $urandom_range(0, 2);
         w    = $urandom_range(0, 3);
         a1   = 32'($urandom_range(0, 255)) << 2;
         a2   = 32'($urandom_range(0, 255)) << 2;
         case (kind)
            0: apply_single(1'b0, 1'b0, 4'h0, a1, 32'h0, w, 1'b0, "rnd_fetch");
            1: apply_single(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), a1, $urandom, w, 1'b0, "rnd_data");
            default: apply_pair(a1, a2, w, "rnd_pair");
         endcase
      end
      spur = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
